// File: rtl/bist_misr_compactor.sv
// Logic-BIST response compactor: folds the scan-chain outputs into a MISR over a
// programmed number of chain unloads, then freezes the signature and reports pass/fail.
module bist_misr_compactor #(
  parameter int                 CHAINS       = 7,
  parameter int                 WIDTH        = 16,
  parameter logic [WIDTH-1:0]   POLY         = 16'h002D,
  parameter logic [WIDTH-1:0]   SEED         = 16'h0000,
  parameter int                 CHAIN_LEN    = 33,
  parameter int                 NUM_PATTERNS = 1000,
  parameter int                 SKIP_FIRST   = 1,
  parameter logic [WIDTH-1:0]   GOLDEN       = 16'h0000
) (
  input  logic              CK,
  input  logic              COMP_reset_n,
  input  logic              bist_en,
  input  logic              scan_en,
  input  logic [CHAINS-1:0] so,
  output logic [WIDTH-1:0]  signature,
  output logic              busy,
  output logic              done,
  output logic              pass
);

  localparam int SC_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int PC_W = $clog2(NUM_PATTERNS + 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(CHAIN_LEN - 1);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(NUM_PATTERNS - 1);
  localparam logic [PC_W-1:0] PC_END  = PC_W'(NUM_PATTERNS);

  typedef enum logic [1:0] {IDLE, PRIME, COMPACT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sig;
  logic [SC_W-1:0]  shift_cnt;
  logic [PC_W-1:0]  pat_cnt;
  logic [WIDTH-1:0] sig_next;

  function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] s,
                                                 input logic [CHAINS-1:0] d);
    logic [WIDTH-1:0] fb;
    fb = s[WIDTH-1] ? POLY : '0;
    return {s[WIDTH-2:0], 1'b0} ^ fb ^ WIDTH'(d);
  endfunction

  assign sig_next  = misr_step(sig, so);
  assign signature = sig;

  always_ff @(posedge CK or negedge COMP_reset_n) begin
    if (!COMP_reset_n) begin
      state     <= IDLE;
      sig       <= SEED;
      shift_cnt <= '0;
      pat_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else if (!bist_en) begin
      // sig deliberately holds so the last signature stays observable after a session
      state     <= IDLE;
      shift_cnt <= '0;
      pat_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sig       <= SEED;
          shift_cnt <= '0;
          pat_cnt   <= '0;
          busy      <= 1'b1;
          state     <= (SKIP_FIRST != 0) ? PRIME : COMPACT;
        end
        PRIME: begin
          if (scan_en) begin
            if (shift_cnt == SC_LAST) begin
              shift_cnt <= '0;
              state     <= COMPACT;
            end else begin
              shift_cnt <= shift_cnt + 1'b1;
            end
          end
        end
        COMPACT: begin
          if (scan_en) begin
            sig <= sig_next;
            if (shift_cnt == SC_LAST) begin
              shift_cnt <= '0;
              if (pat_cnt == PC_LAST) begin
                // last unload: the final compacted value is what gets judged
                pat_cnt <= PC_END;
                state   <= DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
                pass    <= (sig_next == GOLDEN);
              end else begin
                pat_cnt <= pat_cnt + 1'b1;
              end
            end else begin
              shift_cnt <= shift_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          done <= 1'b1;
          pass <= (sig == GOLDEN);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bist_misr_compactor.sv
// Directed bench: MISR arithmetic on a full-size instance, count/skip/pass/abort
// behaviour on a shortened instance (CHAIN_LEN=4, NUM_PATTERNS=2, SKIP_FIRST=1).
module tb_bist_misr_compactor;

  logic        CK;
  logic        rst_n;
  logic        bist_a, bist_b;
  logic        scan_en;
  logic [6:0]  so;
  logic [15:0] sig_a, sig_b;
  logic        busy_a, done_a, pass_a;
  logic        busy_b, done_b, pass_b;

  int checks   = 0;
  int failures = 0;

  bist_misr_compactor #(.SKIP_FIRST(0)) dut_a (
    .CK(CK), .COMP_reset_n(rst_n), .bist_en(bist_a), .scan_en(scan_en), .so(so),
    .signature(sig_a), .busy(busy_a), .done(done_a), .pass(pass_a)
  );

  bist_misr_compactor #(.CHAIN_LEN(4), .NUM_PATTERNS(2), .SKIP_FIRST(1)) dut_b (
    .CK(CK), .COMP_reset_n(rst_n), .bist_en(bist_b), .scan_en(scan_en), .so(so),
    .signature(sig_b), .busy(busy_b), .done(done_b), .pass(pass_b)
  );

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%04h expected=0x%04h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic shifts(input int n, input logic [6:0] v);
    scan_en = 1'b1;
    so      = v;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n = 1'b1; bist_a = 1'b0; bist_b = 1'b0; scan_en = 1'b0; so = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_sig_a", sig_a, 16'h0000);
    chk("rst_busy_a", {15'd0, busy_a}, 16'd0);
    chk("rst_done_b", {15'd0, done_b}, 16'd0);
    chk("rst_pass_b", {15'd0, pass_b}, 16'd0);
    #10 rst_n = 1'b1;
    step();

    // MISR arithmetic on dut_a; start edge does not compact
    bist_a = 1'b1; scan_en = 1'b1; so = 7'h01;
    step();
    chk("start_busy", {15'd0, busy_a}, 16'd1);
    chk("start_sig", sig_a, 16'h0000);
    shifts(1, 7'h01);
    chk("misr_0001", sig_a, 16'h0001);
    shifts(1, 7'h00);
    chk("misr_0002", sig_a, 16'h0002);
    shifts(14, 7'h00);
    chk("misr_8000", sig_a, 16'h8000);
    shifts(1, 7'h00);
    chk("misr_poly", sig_a, 16'h002D);

    // capture cycles are transparent
    scan_en = 1'b0; so = 7'h7F;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("capture_sig", sig_a, 16'h002D);
      chk("capture_busy", {15'd0, busy_a}, 16'd1);
    end
    shifts(1, 7'h7F);
    chk("misr_7f", sig_a, 16'h0025);

    // abort on dut_a: signature held, idle
    bist_a = 1'b0;
    step();
    chk("abort_a_busy", {15'd0, busy_a}, 16'd0);
    chk("abort_a_done", {15'd0, done_a}, 16'd0);
    chk("abort_a_sig", sig_a, 16'h0025);

    // restart then async reset between edges
    bist_a = 1'b1;
    step();
    chk("restart_a_seed", sig_a, 16'h0000);
    shifts(1, 7'h01);
    chk("pre_reset_sig", sig_a, 16'h0001);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_sig", sig_a, 16'h0000);
    chk("areset_busy", {15'd0, busy_a}, 16'd0);
    chk("areset_done", {15'd0, done_a}, 16'd0);
    bist_a = 1'b0; scan_en = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // dut_b run 1: skip window ignores so, done after 12th shift, pass
    bist_b = 1'b1; scan_en = 1'b1; so = 7'h7F;
    step();
    chk("b_start_busy", {15'd0, busy_b}, 16'd1);
    shifts(4, 7'h7F);
    chk("skip_sig", sig_b, 16'h0000);
    chk("skip_done", {15'd0, done_b}, 16'd0);
    shifts(7, 7'h00);
    chk("run1_done_11", {15'd0, done_b}, 16'd0);
    shifts(1, 7'h00);
    chk("run1_done_12", {15'd0, done_b}, 16'd1);
    chk("run1_pass", {15'd0, pass_b}, 16'd1);
    chk("run1_busy", {15'd0, busy_b}, 16'd0);
    shifts(2, 7'h7F);
    chk("run1_frozen", sig_b, 16'h0000);
    chk("run1_pass_hold", {15'd0, pass_b}, 16'd1);

    // run 2: one flipped bit on the last shift fails
    bist_b = 1'b0;
    step();
    chk("drop_done", {15'd0, done_b}, 16'd0);
    chk("drop_pass", {15'd0, pass_b}, 16'd0);
    bist_b = 1'b1;
    step();
    shifts(11, 7'h00);
    shifts(1, 7'h01);
    chk("run2_sig", sig_b, 16'h0001);
    chk("run2_done", {15'd0, done_b}, 16'd1);
    chk("run2_pass", {15'd0, pass_b}, 16'd0);
    shifts(3, 7'h55);
    chk("run2_frozen", sig_b, 16'h0001);

    // run 3: abort mid-COMPACT, then full restart with captures interleaved
    bist_b = 1'b0;
    step();
    bist_b = 1'b1;
    step();
    shifts(4, 7'h00);
    shifts(3, 7'h01);
    chk("run3_sig", sig_b, 16'h0007);
    bist_b = 1'b0;
    step();
    chk("run3_abort_busy", {15'd0, busy_b}, 16'd0);
    chk("run3_abort_done", {15'd0, done_b}, 16'd0);
    chk("run3_abort_sig", sig_b, 16'h0007);
    bist_b = 1'b1;
    step();
    chk("run3_reseed", sig_b, 16'h0000);
    shifts(6, 7'h00);
    scan_en = 1'b0; so = 7'h7F;
    for (int i = 0; i < 5; i++) step();
    chk("run3_cap_busy", {15'd0, busy_b}, 16'd1);
    shifts(5, 7'h00);
    chk("run3_done_11", {15'd0, done_b}, 16'd0);
    shifts(1, 7'h00);
    chk("run3_done_12", {15'd0, done_b}, 16'd1);
    chk("run3_pass", {15'd0, pass_b}, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
